// File: rtl/assoc_cache_wb.sv
// Fully associative write-back, write-allocate cache with true-LRU replacement,
// req/ready CPU port, req/ack memory port, flush walk and saturating hit/miss counters.
module assoc_cache_wb #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int N       = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req,
    input  logic               rw,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic [D_WIDTH-1:0] rdata,
    output logic               ready,
    output logic               hit,
    input  logic               flush,
    output logic               flush_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_EVICT  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_WALLOC = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;

    logic [2:0]         state;
    logic [A_WIDTH-1:0] tag  [N];
    logic [D_WIDTH-1:0] data [N];
    logic [AW-1:0]      age  [N];
    logic [AW-1:0]      age_nxt [N];
    logic [N-1:0]       valid, dirty;
    logic               rw_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic [AW-1:0]      vic, fidx;

    logic               hit_any, vic_found, touch_en, ack_now;
    logic [AW-1:0]      hit_idx, vic_c, touch_idx;

    assign ack_now = mem_req && mem_ack;

    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        vic_found = 1'b0;
        vic_c     = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && tag[i] == addr_q) begin
                hit_any = 1'b1;
                hit_idx = AW'(i);
            end
        end
        // Lowest-index invalid entry wins; otherwise the least recently used one.
        for (int i = 0; i < N; i++) begin
            if (!vic_found && !valid[i]) begin
                vic_found = 1'b1;
                vic_c     = AW'(i);
            end
        end
        if (!vic_found) begin
            for (int i = 0; i < N; i++) begin
                if (age[i] == '0) vic_c = AW'(i);
            end
        end
    end

    always_comb begin
        touch_en  = 1'b0;
        touch_idx = vic;
        case (state)
            S_LOOKUP: begin
                touch_en  = hit_any;
                touch_idx = hit_idx;
            end
            S_FILL:   touch_en = ack_now;
            S_WALLOC: touch_en = 1'b1;
            default:  touch_en = 1'b0;
        endcase
        for (int i = 0; i < N; i++) begin
            age_nxt[i] = age[i];
            if (touch_en) begin
                if (AW'(i) == touch_idx) age_nxt[i] = AW'(N - 1);
                else if (age[i] > age[touch_idx]) age_nxt[i] = age[i] - AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (clr) age[i] <= AW'(i);
            else     age[i] <= age_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            valid      <= '0;
            dirty      <= '0;
            ready      <= 1'b0;
            hit        <= 1'b0;
            flush_done <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            fidx       <= '0;
            vic        <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            ready      <= 1'b0;
            hit        <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        fidx  <= '0;
                        state <= S_FLUSH;
                    end else if (req) begin
                        rw_q    <= rw;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_any) begin
                        ready <= 1'b1;
                        hit   <= 1'b1;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                        if (rw_q) begin
                            data[hit_idx]  <= wdata_q;
                            dirty[hit_idx] <= 1'b1;
                        end else begin
                            rdata <= data[hit_idx];
                        end
                        state <= S_IDLE;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                        vic <= vic_c;
                        if (valid[vic_c] && dirty[vic_c]) state <= S_EVICT;
                        else if (rw_q)                    state <= S_WALLOC;
                        else                              state <= S_FILL;
                    end
                end
                // mem_req is raised one cycle after entry and dropped on ack, so the
                // address/data never change under an active request.
                S_EVICT: begin
                    if (ack_now) begin
                        mem_req <= 1'b0;
                        state   <= rw_q ? S_WALLOC : S_FILL;
                    end else if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= tag[vic];
                        mem_wdata <= data[vic];
                    end
                end
                S_FILL: begin
                    if (ack_now) begin
                        mem_req    <= 1'b0;
                        data[vic]  <= mem_rdata;
                        tag[vic]   <= addr_q;
                        valid[vic] <= 1'b1;
                        dirty[vic] <= 1'b0;
                        rdata      <= mem_rdata;
                        ready      <= 1'b1;
                        state      <= S_IDLE;
                    end else if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_q;
                    end
                end
                S_WALLOC: begin
                    data[vic]  <= wdata_q;
                    tag[vic]   <= addr_q;
                    valid[vic] <= 1'b1;
                    dirty[vic] <= 1'b1;
                    ready      <= 1'b1;
                    state      <= S_IDLE;
                end
                S_FLUSH: begin
                    if (valid[fidx] && dirty[fidx] && !ack_now) begin
                        if (!mem_req) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= tag[fidx];
                            mem_wdata <= data[fidx];
                        end
                    end else begin
                        if (ack_now) mem_req <= 1'b0;
                        valid[fidx] <= 1'b0;
                        dirty[fidx] <= 1'b0;
                        if (fidx == AW'(N - 1)) begin
                            flush_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            fidx <= fidx + AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_cache_wb.sv
// Directed bench for assoc_cache_wb: vector table of CPU accesses with hand-computed
// results and expected memory transactions, plus flush and mid-fill reset sequences.
module tb_assoc_cache_wb;
    logic       clk = 1'b0;
    logic       clr, req, rw, flush, mem_ack;
    logic [7:0] addr, wdata, mem_rdata;
    logic [7:0] rdata, mem_addr, mem_wdata;
    logic       ready, hit, flush_done, mem_req, mem_we;
    logic [15:0] hit_cnt, miss_cnt;

    assoc_cache_wb dut (
        .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .hit(hit), .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mem_log[$];
    logic [7:0]  ram [256];
    int          mem_lat = 1;
    int          fd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mw(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] mr(input logic [7:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    // Memory model: acks mem_lat posedges after it first sees mem_req.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [16:0] m_txn;

    task automatic fire();
        m_busy  = 1'b0;
        mem_ack = 1'b1;
        chk("mem stable", {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00}, m_txn);
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata = ram[mem_addr];
    endtask

    always @(negedge clk) begin
        if (flush_done === 1'b1) fd_cnt++;
        if (clr) begin
            mem_ack = 1'b0;
            m_busy  = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt <= 0) fire();
        end else if (mem_req === 1'b1) begin
            m_txn = {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00};
            mem_log.push_back(m_txn);
            m_busy = 1'b1;
            m_cnt  = mem_lat - 1;
            if (m_cnt <= 0) fire();
        end
    end

    task automatic check_mem(input string name);
        chk({name, " memcnt"}, mem_log.size(), exp_q.size());
        while (exp_q.size() > 0 && mem_log.size() > 0)
            chk({name, " memtxn"}, mem_log.pop_front(), exp_q.pop_front());
        exp_q.delete();
        mem_log.delete();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d,
                          output logic h, output logic [7:0] rd, output int lat);
        bit ok;
        req = 1'b1; rw = w; addr = a; wdata = d; lat = 0; ok = 0; h = 1'bx; rd = 8'hxx;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ready) begin
                h = hit; rd = rdata; ok = 1;
                break;
            end
        end
        req = 1'b0;
        chk("ready timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        bit          rst;
        bit          w;
        logic [7:0]  a, d;
        bit          eh, crd;
        logic [7:0]  erd;
        int          hc, mc, nm;
        logic [16:0] m0, m1;
        bit          ren;
        logic [7:0]  ra, rv;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit rst, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit eh, input bit crd, input logic [7:0] erd, input int hc,
                       input int mc, input int nm, input logic [16:0] m0, input logic [16:0] m1,
                       input bit ren, input logic [7:0] ra, input logic [7:0] rv);
        vec_t v;
        v.rst = rst; v.w = w; v.a = a; v.d = d; v.eh = eh; v.crd = crd; v.erd = erd;
        v.hc = hc; v.mc = mc; v.nm = nm; v.m0 = m0; v.m1 = m1; v.ren = ren; v.ra = ra; v.rv = rv;
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       h;
        logic [7:0] rd;
        int         lat, fd0;
        bit         ok;

        for (int i = 0; i < 256; i++) ram[i] = 8'hFF ^ 8'(i);
        ram[8'h10] = 8'h5A;
        clr = 1'b1; req = 0; rw = 0; addr = 0; wdata = 0; flush = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", 32'(ready), 0);
        chk("rst hit", 32'(hit), 0);
        chk("rst flush_done", 32'(flush_done), 0);
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst rdata", 32'(rdata), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_wdata", 32'(mem_wdata), 0);
        chk("rst hit_cnt", 32'(hit_cnt), 0);
        chk("rst miss_cnt", 32'(miss_cnt), 0);
        clr = 1'b0;

        // rst  w  addr   data   hit crd rdata  hc mc nm m0             m1         ram check
        add(1, 0, 8'h10, 8'h00, 0, 1, 8'h5A, 0, 1, 1, mr(8'h10),      0,         0, 0, 0);
        add(0, 0, 8'h10, 8'h00, 1, 1, 8'h5A, 1, 1, 0, 0,              0,         0, 0, 0);
        add(0, 1, 8'h20, 8'hAA, 0, 0, 8'h00, 1, 2, 0, 0,              0,         0, 0, 0);
        add(0, 0, 8'h20, 8'h00, 1, 1, 8'hAA, 2, 2, 0, 0,              0,         1, 8'h20, 8'hDF);
        add(0, 1, 8'h10, 8'h3C, 1, 0, 8'h00, 3, 2, 0, 0,              0,         0, 0, 0);
        add(0, 0, 8'h10, 8'h00, 1, 1, 8'h3C, 4, 2, 0, 0,              0,         1, 8'h10, 8'h5A);
        // LRU selection
        add(1, 0, 8'h01, 8'h00, 0, 1, 8'hFE, 0, 1, 1, mr(8'h01),      0,         0, 0, 0);
        add(0, 0, 8'h02, 8'h00, 0, 1, 8'hFD, 0, 2, 1, mr(8'h02),      0,         0, 0, 0);
        add(0, 0, 8'h03, 8'h00, 0, 1, 8'hFC, 0, 3, 1, mr(8'h03),      0,         0, 0, 0);
        add(0, 0, 8'h04, 8'h00, 0, 1, 8'hFB, 0, 4, 1, mr(8'h04),      0,         0, 0, 0);
        add(0, 0, 8'h01, 8'h00, 1, 1, 8'hFE, 1, 4, 0, 0,              0,         0, 0, 0);
        add(0, 0, 8'h05, 8'h00, 0, 1, 8'hFA, 1, 5, 1, mr(8'h05),      0,         0, 0, 0);
        add(0, 0, 8'h01, 8'h00, 1, 1, 8'hFE, 2, 5, 0, 0,              0,         0, 0, 0);
        add(0, 0, 8'h02, 8'h00, 0, 1, 8'hFD, 2, 6, 1, mr(8'h02),      0,         0, 0, 0);
        // dirty eviction ordering
        add(1, 1, 8'h01, 8'h11, 0, 0, 8'h00, 0, 1, 0, 0,              0,         0, 0, 0);
        add(0, 1, 8'h02, 8'h22, 0, 0, 8'h00, 0, 2, 0, 0,              0,         0, 0, 0);
        add(0, 1, 8'h03, 8'h33, 0, 0, 8'h00, 0, 3, 0, 0,              0,         0, 0, 0);
        add(0, 1, 8'h04, 8'h44, 0, 0, 8'h00, 0, 4, 0, 0,              0,         0, 0, 0);
        add(0, 0, 8'h05, 8'h00, 0, 1, 8'hFA, 0, 5, 2, mw(8'h01, 8'h11), mr(8'h05), 1, 8'h01, 8'h11);
        add(0, 0, 8'h02, 8'h00, 1, 1, 8'h22, 1, 5, 0, 0,              0,         0, 0, 0);
        // flush setup: two dirty, two clean
        add(1, 1, 8'h02, 8'h22, 0, 0, 8'h00, 0, 1, 0, 0,              0,         0, 0, 0);
        add(0, 1, 8'h03, 8'h33, 0, 0, 8'h00, 0, 2, 0, 0,              0,         0, 0, 0);
        add(0, 0, 8'h06, 8'h00, 0, 1, 8'hF9, 0, 3, 1, mr(8'h06),      0,         0, 0, 0);
        add(0, 0, 8'h07, 8'h00, 0, 1, 8'hF8, 0, 4, 1, mr(8'h07),      0,         0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            v = vecs[k];
            if (v.rst) do_clr();
            if (v.nm >= 1) exp_q.push_back(v.m0);
            if (v.nm >= 2) exp_q.push_back(v.m1);
            access(v.w, v.a, v.d, h, rd, lat);
            chk($sformatf("v%0d hit", k), 32'(h), 32'(v.eh));
            if (v.crd) chk($sformatf("v%0d rdata", k), 32'(rd), 32'(v.erd));
            if (v.eh) chk($sformatf("v%0d latency", k), lat, 2);
            chk($sformatf("v%0d hit_cnt", k), 32'(hit_cnt), v.hc);
            chk($sformatf("v%0d miss_cnt", k), 32'(miss_cnt), v.mc);
            check_mem($sformatf("v%0d", k));
            if (v.ren) chk($sformatf("v%0d ram", k), 32'(ram[v.ra]), 32'(v.rv));
        end

        // Flush: dirty 0x02/0x03 written back in entry order, single done pulse.
        exp_q.push_back(mw(8'h02, 8'h22));
        exp_q.push_back(mw(8'h03, 8'h33));
        fd0 = fd_cnt;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (fd_cnt > fd0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("flush timeout", 32'(ok), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_done pulses", fd_cnt - fd0, 1);
        check_mem("flush");
        exp_q.push_back(mr(8'h02));
        access(0, 8'h02, 8'h00, h, rd, lat);
        chk("post-flush 02 hit", 32'(h), 0);
        chk("post-flush 02 rdata", 32'(rd), 32'h22);
        check_mem("post-flush 02");
        exp_q.push_back(mr(8'h06));
        access(0, 8'h06, 8'h00, h, rd, lat);
        chk("post-flush 06 hit", 32'(h), 0);
        access(1, 8'h30, 8'h77, h, rd, lat);
        chk("w30 hit", 32'(h), 0);
        check_mem("post-flush 06/30");

        // flush and req together: flush writes 0x30 back, then the read misses.
        exp_q.push_back(mw(8'h30, 8'h77));
        exp_q.push_back(mr(8'h30));
        fd0 = fd_cnt;
        flush = 1'b1; req = 1'b1; rw = 1'b0; addr = 8'h30;
        ok = 0;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                h = hit; rd = rdata; ok = 1;
                break;
            end
        end
        req = 1'b0;
        chk("flush+req timeout", 32'(ok), 1);
        chk("flush before req", fd_cnt - fd0, 1);
        chk("flush+req hit", 32'(h), 0);
        chk("flush+req rdata", 32'(rd), 32'h77);
        chk("flush+req miss_cnt", 32'(miss_cnt), 8);
        chk("flush+req hit_cnt", 32'(hit_cnt), 0);
        check_mem("flush+req");

        // Reset while FILL waits on a slow ack.
        do_clr();
        exp_q.push_back(mr(8'h10));
        access(0, 8'h10, 8'h00, h, rd, lat);
        chk("pre-clr rdata", 32'(rd), 32'h5A);
        mem_lat = 5;
        exp_q.push_back(mr(8'h11));
        req = 1'b1; rw = 1'b0; addr = 8'h11;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                ok = 1;
                break;
            end
        end
        chk("fill mem_req seen", 32'(ok), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        clr = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        chk("clr mem_req", 32'(mem_req), 0);
        chk("clr ready", 32'(ready), 0);
        chk("clr hit_cnt", 32'(hit_cnt), 0);
        chk("clr miss_cnt", 32'(miss_cnt), 0);
        clr = 1'b0;
        check_mem("aborted fill");
        mem_lat = 1;
        exp_q.push_back(mr(8'h10));
        access(0, 8'h10, 8'h00, h, rd, lat);
        chk("after clr 10 hit", 32'(h), 0);
        chk("after clr 10 rdata", 32'(rd), 32'h5A);
        chk("after clr miss_cnt", 32'(miss_cnt), 1);
        check_mem("after clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
